// File: rtl/gpout_bank.sv
// Bank of CHANNELS debug outputs, each selecting one of 2**SEL_W sources with
// direct / registered / sticky / toggle capture, plus a shared programmable clock divider.
module gpout_bank #(
    parameter int CHANNELS = 6,
    parameter int SEL_W    = 6,
    parameter int DIV_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2**SEL_W-1:0]   i_src,
    input  logic [CHANNELS-1:0]   i_primary,
    input  logic [CHANNELS-1:0]   i_alt,
    input  logic                  i_cfg_we,
    input  logic [3:0]            i_cfg_ch,
    input  logic [SEL_W-1:0]      i_cfg_sel,
    input  logic [1:0]            i_cfg_mode,
    input  logic                  i_div_we,
    input  logic [DIV_W-1:0]      i_div,
    input  logic                  i_clear,
    output logic [CHANNELS-1:0]   o_gpout,
    output logic                  o_div_clk
);

    // No handshake anywhere: a strobe (i_cfg_we, i_div_we, i_clear) is consumed on
    // the clock edge where it is high; there is no ready and nothing is ever stalled.

    localparam logic [1:0] M_DIRECT = 2'd0;
    localparam logic [1:0] M_REG    = 2'd1;
    localparam logic [1:0] M_STICKY = 2'd2;
    localparam logic [1:0] M_TOGGLE = 2'd3;

    logic [SEL_W-1:0]    r_sel  [CHANNELS];
    logic [1:0]          r_mode [CHANNELS];
    logic [CHANNELS-1:0] r_q;
    logic [CHANNELS-1:0] r_prev;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_ratio;
    logic                r_div_clk;

    logic [CHANNELS-1:0] w_v;
    logic [CHANNELS-1:0] w_hit;

    assign o_div_clk = r_div_clk;

    // Source map: sources 0-3 are overridden per channel; the raw clock is only
    // passed through in direct mode so no flop ever samples it as data.
    always_comb begin
        w_v     = '0;
        w_hit   = '0;
        o_gpout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_hit[c] = i_cfg_we && (i_cfg_ch == 4'(c));
            if (r_sel[c] == SEL_W'(0))
                w_v[c] = i_primary[c];
            else if (r_sel[c] == SEL_W'(1))
                w_v[c] = i_alt[c];
            else if (r_sel[c] == SEL_W'(2))
                w_v[c] = (r_mode[c] == M_DIRECT) ? clk : 1'b0;
            else if (r_sel[c] == SEL_W'(3))
                w_v[c] = r_div_clk;
            else
                w_v[c] = i_src[r_sel[c]];
            o_gpout[c] = (r_mode[c] == M_DIRECT) ? w_v[c] : r_q[c];
        end
    end

    // Per channel: config write beats clear, clear beats the normal mode update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sel[c]  <= '0;
                r_mode[c] <= M_DIRECT;
            end
            r_q    <= '0;
            r_prev <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_hit[c]) begin
                    r_sel[c]  <= i_cfg_sel;
                    r_mode[c] <= i_cfg_mode;
                    r_q[c]    <= 1'b0;
                    r_prev[c] <= 1'b0;
                end else begin
                    r_prev[c] <= w_v[c];
                    case (r_mode[c])
                        M_REG:    r_q[c] <= w_v[c];
                        M_STICKY: r_q[c] <= i_clear ? 1'b0 : (r_q[c] | w_v[c]);
                        M_TOGGLE: r_q[c] <= i_clear ? 1'b0 : (r_q[c] ^ (w_v[c] & ~r_prev[c]));
                        default:  r_q[c] <= r_q[c];
                    endcase
                end
            end
        end
    end

    // Divider: a ratio write restarts the count but holds the current output level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ratio   <= '0;
            r_div_clk <= 1'b0;
        end else if (i_div_we) begin
            r_ratio <= i_div;
            r_cnt   <= '0;
        end else if (r_cnt == r_ratio) begin
            r_cnt     <= '0;
            r_div_clk <= ~r_div_clk;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: doc/gpout_bank.md
# gpout_bank

Parametrised successor to the six-channel general-purpose output mux. It drives `CHANNELS` debug outputs, and each channel selects one of `2**SEL_W` sources. Each channel's select and capture mode are held in internal registers written through a simple config port, so the selects no longer need to be held by external pins. Each channel adds registered, sticky-latch and edge-toggle capture modes, plus a programmable shared clock divider. It sits between rbzero/top-level signals and the pad/LA mux that feeds external debug pins.

## Interface
Parameters:
- `CHANNELS`, 6: number of gpout channels (1–16).
- `SEL_W`, 6: width of a channel select; source space is `2**SEL_W`.
- `DIV_W`, 4: width of the clock-divider ratio.

Ports:
- `clk`  in  1  sole clock; also selectable as source 2.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `i_src`  in  `2**SEL_W`  shared sources; bits 0–3 ignored (overridden below).
- `i_primary`  in  `CHANNELS`  per-channel source 0.
- `i_alt`  in  `CHANNELS`  per-channel source 1.
- `i_cfg_we`  in  1  config write strobe, single cycle.
- `i_cfg_ch`  in  4  target channel of the write.
- `i_cfg_sel`  in  `SEL_W`  new select value.
- `i_cfg_mode`  in  2  new mode: 0 direct, 1 registered, 2 sticky, 3 toggle.
- `i_div_we`  in  1  divider-ratio write strobe.
- `i_div`  in  `DIV_W`  new divider ratio R.
- `i_clear`  in  1  clears sticky/toggle state on all channels.
- `o_gpout`  out  `CHANNELS`  channel outputs.
- `o_div_clk`  out  1  divided clock, period 2·(R+1) clk cycles.

## Operation
Source map, per channel `c`, for select `s`:
- 0 → `i_primary[c]`.
- 1 → `i_alt[c]`.
- 2 → `clk` in mode 0, constant 0 in modes 1–3.
- 3 → `o_div_clk`.
- 4 and above → `i_src[s]`.
- The selected value is called `v`.

Per-channel state:
- `sel` (reset 0), `mode` (reset 0), `q` (reset 0), `prev` (reset 0).
- `prev` samples `v` every cycle in every mode.

Modes:
- 0 direct: `o_gpout[c] = v`, purely combinational.
- 1 registered: `q <= v`; `o_gpout[c] = q`.
- 2 sticky: `q <= q | v`; `o_gpout[c] = q`. It stays high until clear or reconfig.
- 3 toggle: on a rising edge of `v` (`v & ~prev`), `q <= ~q`; `o_gpout[c] = q`. This halves edge rate for scoping fast strobes.

Config writes:
- `i_cfg_we` with `i_cfg_ch < CHANNELS` loads that channel's `sel` and `mode`, and zeroes its `q` and `prev`.
- The new selection drives the output from the next cycle.
- `i_cfg_ch >= CHANNELS`: the write is ignored; no state changes.

Clear:
- `i_clear` zeroes `q` on all channels in modes 2 and 3.
- In mode 1 `q` still samples `v`.

Divider:
- Counter `cnt` (`DIV_W` bits, reset 0), ratio R (reset 0), `o_div_clk` (reset 0).
- Each cycle: if `cnt == R`, then `cnt <= 0` and `o_div_clk` toggles; otherwise `cnt <= cnt + 1`.
- `i_div_we` loads R, sets `cnt <= 0`, and leaves `o_div_clk` at its current level.

## Timing
- Reset values: every `sel` = 0 and `mode` = 0, so `o_gpout[c] = i_primary[c]` combinationally during and after reset. `o_div_clk` = 0, all `q` = 0.
- Reset has priority over `i_cfg_we`, `i_div_we` and `i_clear`.
- Latency:
  - mode 0: 0 cycles.
  - mode 1: 1 cycle.
  - mode 2: set visible 1 cycle after `v` = 1.
  - mode 3: toggle visible 1 cycle after the rising-edge cycle.
- Priority per channel: config write > clear > mode update.
  - A clear in the same cycle as a sticky set leaves `q` = 0.
  - A config write in the same cycle as a clear leaves `q` = 0 and `prev` = 0.
- Toggle after reconfig: `prev` = 0, so a `v` already high on the first cycle after a write counts as a rising edge.
- Divider write on the same cycle as `cnt == R`: the write wins; there is no toggle that cycle.
- R = 0 gives `o_div_clk` = clk/2.
- No handshake. Config writes are accepted every cycle, including back-to-back writes to the same channel (the last write wins).

## Test plan
1. Reset, then drive `i_primary` = 6'b101010 → `o_gpout` = 6'b101010 in the same cycle; `o_div_clk` = 0.
2. Write ch2 sel = 9, mode 1; pulse `i_src[9]` high for 1 cycle at cycle T → `o_gpout[2]` high only in cycle T+1.
3. Write ch0 mode 2, sel = 12; 1-cycle pulse on `i_src[12]` → `o_gpout[0]` stays 1. Then `i_clear` together with a second pulse → `o_gpout[0]` = 0 the next cycle.
4. Write ch5 mode 3, sel = 20; drive 4 separate rising edges on `i_src[20]` → `o_gpout[5]` toggles 0→1→0→1→0, one cycle after each edge. A level held high gives no extra toggle.
5. Write R = 3 → `o_div_clk` period 8 clk cycles, measured from the write. Write R = 0 mid-count → period 2 with no glitch, and the current level is held across the write.
6. Write with `i_cfg_ch` = 7 (`CHANNELS` = 6) → no output or state change. Write ch1 sel = 63, mode 0 → `o_gpout[1]` follows `i_src[63]` combinationally.
